keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the calculator's 5-row × 4-column matrix keypad and produces a debounced, registered key position. It sits directly upstream of the key-address decoder: its `rowOut`/`colOut` outputs feed that decoder unchanged, and its `key_valid` pulse tells the calculator core when the decoded address is a new keypress.

## Interface

**Parameters**
- `SCAN_DIV`, default 50000: clock cycles each row stays driven during scanning.
- `DEBOUNCE_CYCLES`, default 10: consecutive identical column samples needed to accept a press or a release.
- `REPEAT_CYCLES`, default 25000000: auto-repeat interval, used only when `KEY_REPEAT_EN` is defined.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `row_drv` out 5: physical row drive, active-low one-hot. Reset value 5'b11110 (row 0).
- `col_in` in 4: physical column sense, active-low, externally pulled up. Asynchronous.
- `rowOut` out 5: row of the accepted key, active-high one-hot. Value 0 when no key is held. Reset value 0.
- `colOut` out 4: column of the accepted key, active-low one-hot. Value 4'b1111 when no key is held. Reset value 4'b1111.
- `key_valid` out 1: one-cycle pulse marking a new accepted key. Reset value 0.
- `key_held` out 1: high while an accepted key is down. Reset value 0.

## Operation
- `col_in` passes through a 2-flop synchronizer. Every sample below means the synchronized value `col_s`.
- The FSM has four states: SCAN, DEBOUNCE, PRESSED, RELEASE. Reset enters SCAN at row 0 with all counters cleared.
- **SCAN**
  - The row index walks 0→1→2→3→4→0. `row_drv` changes every `SCAN_DIV` cycles.
  - `col_s` is sampled on the last cycle of each row slot.
  - Exactly one bit low: latch the row index and the `col_s` pattern, freeze `row_drv`, go to DEBOUNCE.
  - All bits high, or two or more bits low (ghost/multi-key): advance to the next row.
- **DEBOUNCE**
  - Sample every cycle. Go to PRESSED after `DEBOUNCE_CYCLES` consecutive samples equal to the latched pattern.
  - Any mismatch: return to SCAN at the next row.
- **PRESSED**
  - On entry, load `rowOut`/`colOut` from the latches, pulse `key_valid`, and set `key_held`.
  - Stay in PRESSED while the latched column bit remains low. When `col_s` reads all-high, go to RELEASE.
- **RELEASE**
  - After `DEBOUNCE_CYCLES` consecutive all-high samples: clear `rowOut` to 0, set `colOut` to 4'b1111, drop `key_held`, return to SCAN at row 0.
  - Any low sample before the count completes: return to PRESSED with no new `key_valid`.
- A second key pressed while in PRESSED is ignored.
- `rst` asserted in any state takes effect on the next edge: all outputs go to their reset values and any pending `key_valid` is suppressed.

## Timing
- Press latency, from a stable `col_in` change to the `key_valid` cycle: at most 2 (sync) + 5·`SCAN_DIV` (worst-case scan position) + `DEBOUNCE_CYCLES` + 1.
- `key_valid` is asserted in the same cycle that `rowOut`/`colOut` take the new key. All three outputs are registered.
- `rowOut`/`colOut` hold steady from the `key_valid` cycle until the release is accepted.
- The scan-slot counter wraps to 0 at `SCAN_DIV`-1. The row index wraps 4→0.
- Counters are sized by `$clog2`. The debounce counter saturates and never wraps.

## Configuration
- `KEY_REPEAT_EN` defined:
  - In PRESSED, a repeat counter starts at the `key_valid` cycle.
  - Every `REPEAT_CYCLES` cycles it emits another one-cycle `key_valid`; `rowOut`/`colOut` are unchanged.
  - The counter clears on exit from PRESSED. A RELEASE→PRESSED bounce restarts it.
- `KEY_REPEAT_EN` undefined: no repeat logic. Exactly one `key_valid` per accepted press.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_CYCLES`=32.
- **Reset values:** assert `rst` for 2 cycles → `row_drv`=5'b11110, `rowOut`=0, `colOut`=4'b1111, `key_valid`=0, `key_held`=0.
- **Clean press:** model the key at row 1, column 1 (pull `col_in` bit 1 low only while `row_drv`=5'b11101) → exactly one `key_valid` with `rowOut`=5'b00010 and `colOut`=4'b1101; `key_held`=1 until 8 cycles of release complete, then `rowOut`=0 and `colOut`=4'b1111.
- **Bounce:** toggle the key for 5 cycles, then hold stable → exactly one `key_valid`. Toggle only 3-cycle glitches → no `key_valid` at all.
- **Ghost rejection:** two columns low (`col_in`=4'b1001) on row 3 → no `key_valid`, and scanning continues to row 4.
- **Release chatter:** with the key held, release for 5 cycles, re-press, then release cleanly → no second `key_valid`; `key_held` stays high throughout the chatter.
- **Mid-debounce reset and repeat:** assert `rst` during DEBOUNCE → no `key_valid`, scanning restarts at row 0. With `KEY_REPEAT_EN`, hold the key for 100 cycles after acceptance → 4 `key_valid` pulses in total (initial, then +32, +64, +96).

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 active-low matrix keypad, debounces the press
// and the release, and presents the accepted key as registered rowOut/colOut
// with a one-cycle key_valid pulse.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat key_valid while held).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] row_drv,
    input  logic [3:0] col_in,
    output logic [4:0] rowOut,
    output logic [3:0] colOut,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

    state_e            r_state,    w_state_nxt;
    logic [3:0]        r_col_meta, r_col_s;
    logic [2:0]        r_row_idx,  w_row_idx_nxt;
    logic [SLOT_W-1:0] r_slot,     w_slot_nxt;
    logic [DEB_W-1:0]  r_deb,      w_deb_nxt;
    logic [2:0]        r_lat_row,  w_lat_row_nxt;
    logic [3:0]        r_lat_col,  w_lat_col_nxt;
    logic [4:0]        r_row_out,  w_row_out_nxt;
    logic [3:0]        r_col_out,  w_col_out_nxt;
    logic              r_valid,    w_valid_nxt;
    logic              r_held,     w_held_nxt;
    logic              w_one_low;
    logic              w_all_high;
    logic [2:0]        w_row_next;
    logic [DEB_W-1:0]  w_deb_inc;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0]  r_rep, w_rep_nxt;
`endif

    assign w_one_low  = ($countones(r_col_s) == 3);
    assign w_all_high = (r_col_s == 4'b1111);
    assign w_row_next = (r_row_idx == 3'd4) ? 3'd0 : r_row_idx + 3'd1;
    // Debounce counter saturates rather than wrapping.
    assign w_deb_inc  = (r_deb == DEB_MAX) ? r_deb : r_deb + DEB_W'(1);

    assign row_drv   = ~(5'b00001 << r_row_idx);
    assign rowOut    = r_row_out;
    assign colOut    = r_col_out;
    assign key_valid = r_valid;
    assign key_held  = r_held;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'b1111;
            r_col_s    <= 4'b1111;
        end else begin
            r_col_meta <= col_in;
            r_col_s    <= r_col_meta;
        end
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StScan;
            r_row_idx <= 3'd0;
            r_slot    <= '0;
            r_deb     <= '0;
            r_lat_row <= 3'd0;
            r_lat_col <= 4'b1111;
            r_row_out <= 5'b00000;
            r_col_out <= 4'b1111;
            r_valid   <= 1'b0;
            r_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_row_idx <= w_row_idx_nxt;
            r_slot    <= w_slot_nxt;
            r_deb     <= w_deb_nxt;
            r_lat_row <= w_lat_row_nxt;
            r_lat_col <= w_lat_col_nxt;
            r_row_out <= w_row_out_nxt;
            r_col_out <= w_col_out_nxt;
            r_valid   <= w_valid_nxt;
            r_held    <= w_held_nxt;
`ifdef KEY_REPEAT_EN
            r_rep     <= w_rep_nxt;
`endif
        end
    end

    // Next-state and output decode for the scan/debounce/press/release FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_slot_nxt    = r_slot;
        w_deb_nxt     = r_deb;
        w_lat_row_nxt = r_lat_row;
        w_lat_col_nxt = r_lat_col;
        w_row_out_nxt = r_row_out;
        w_col_out_nxt = r_col_out;
        w_valid_nxt   = 1'b0;
        w_held_nxt    = r_held;
`ifdef KEY_REPEAT_EN
        w_rep_nxt     = '0;
`endif
        unique case (r_state)
            StScan: begin
                if (r_slot == SLOT_LAST) begin
                    w_slot_nxt = '0;
                    if (w_one_low) begin
                        w_lat_row_nxt = r_row_idx;
                        w_lat_col_nxt = r_col_s;
                        w_deb_nxt     = '0;
                        w_state_nxt   = StDebounce;
                    end else begin
                        // No key, or a ghost/multi-key pattern: keep scanning.
                        w_row_idx_nxt = w_row_next;
                    end
                end else begin
                    w_slot_nxt = r_slot + SLOT_W'(1);
                end
            end
            StDebounce: begin
                if (r_col_s == r_lat_col) begin
                    if (r_deb == DEB_LAST) begin
                        w_state_nxt   = StPressed;
                        w_row_out_nxt = 5'b00001 << r_lat_row;
                        w_col_out_nxt = r_lat_col;
                        w_valid_nxt   = 1'b1;
                        w_held_nxt    = 1'b1;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    w_state_nxt   = StScan;
                    w_row_idx_nxt = w_row_next;
                    w_slot_nxt    = '0;
                end
            end
            StPressed: begin
                if (w_all_high) begin
                    w_state_nxt = StRelease;
                    w_deb_nxt   = '0;
                end
`ifdef KEY_REPEAT_EN
                else if (r_rep == REP_LAST) begin
                    w_valid_nxt = 1'b1;
                end else begin
                    w_rep_nxt = r_rep + REP_W'(1);
                end
`endif
            end
            StRelease: begin
                if (w_all_high) begin
                    if (r_deb == DEB_LAST) begin
                        w_state_nxt   = StScan;
                        w_row_idx_nxt = 3'd0;
                        w_slot_nxt    = '0;
                        w_row_out_nxt = 5'b00000;
                        w_col_out_nxt = 4'b1111;
                        w_held_nxt    = 1'b0;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    // Release chatter: back to held without a new key_valid.
                    w_state_nxt = StPressed;
                end
            end
            default: w_state_nxt = StScan;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8,
// REPEAT_CYCLES=32). Honours KEY_REPEAT_EN when defined for the build.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [4:0] row_drv;
    logic [3:0] col_in;
    logic [4:0] rowOut;
    logic [3:0] colOut;
    logic       key_valid;
    logic       key_held;

    // Key model: one switch at (key_row, pattern key_pat) visible while its row is driven.
    logic       key_on;
    logic [2:0] key_row;
    logic [3:0] key_pat;

    int total = 0;
    int bad   = 0;
    int n_pulse = 0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_drv  (row_drv),
        .col_in   (col_in),
        .rowOut   (rowOut),
        .colOut   (colOut),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'b1111;
        if (key_on && (row_drv[key_row] == 1'b0)) col_in = key_pat;
    end

    // Count key_valid pulses (one per high cycle).
    always @(posedge clk) begin
        if (key_valid === 1'b1) n_pulse = n_pulse + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_held(input logic v, input string tag);
        int n = 0;
        while (key_held !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(key_held), 32'(v));
    endtask

    initial begin
        int base;
        int n;
        logic held_ok;

        rst     = 1'b1;
        key_on  = 1'b0;
        key_row = 3'd0;
        key_pat = 4'b1111;

        // Reset values
        tick(2);
        chk("rst_row_drv",   32'(row_drv),   32'h1e);
        chk("rst_rowOut",    32'(rowOut),    32'h00);
        chk("rst_colOut",    32'(colOut),    32'hf);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_held",  32'(key_held),  32'd0);
        rst = 1'b0;

        // Clean press at row 1, column 1
        base    = n_pulse;
        key_row = 3'd1;
        key_pat = 4'b1101;
        key_on  = 1'b1;
        wait_valid("press_valid");
        chk("press_rowOut",  32'(rowOut),   32'h02);
        chk("press_colOut",  32'(colOut),   32'hd);
        chk("press_held",    32'(key_held), 32'd1);
        chk("press_row_drv", 32'(row_drv),  32'h1d);
        tick(20);
        chk("press_one_pulse", 32'(n_pulse - base), 32'd1);
        chk("press_held_hold", 32'(key_held), 32'd1);
        chk("press_rowOut_hold", 32'(rowOut), 32'h02);
        key_on = 1'b0;
        n = 0;
        while (key_held !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        // 2 sync edges + 1 edge to enter release + 8 all-high samples
        chk("release_cycles", 32'(n), 32'd11);
        chk("release_rowOut", 32'(rowOut), 32'h00);
        chk("release_colOut", 32'(colOut), 32'hf);
        chk("release_row0",   32'(row_drv), 32'h1e);
        chk("release_pulses", 32'(n_pulse - base), 32'd1);

        // Bounce: 5 toggling cycles then stable
        base = n_pulse;
        for (int i = 0; i < 5; i++) begin
            key_on = ~key_on;
            tick(1);
        end
        key_on = 1'b1;
        wait_held(1'b1, "bounce_held");
        tick(20);
        chk("bounce_one_pulse", 32'(n_pulse - base), 32'd1);
        chk("bounce_rowOut",    32'(rowOut), 32'h02);
        key_on = 1'b0;
        wait_held(1'b0, "bounce_release");

        // 3-cycle glitches only
        base = n_pulse;
        for (int i = 0; i < 12; i++) begin
            key_on = 1'b1;
            tick(3);
            key_on = 1'b0;
            tick(3);
        end
        tick(40);
        chk("glitch_no_pulse", 32'(n_pulse - base), 32'd0);
        chk("glitch_no_held",  32'(key_held), 32'd0);

        // Ghost: two columns low on row 3
        base    = n_pulse;
        key_row = 3'd3;
        key_pat = 4'b1001;
        key_on  = 1'b1;
        n = 0;
        while (row_drv !== 5'b10111 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ghost_reach_row3", 32'(row_drv), 32'h17);
        n = 0;
        while (row_drv === 5'b10111 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ghost_next_row4", 32'(row_drv), 32'h0f);
        tick(60);
        chk("ghost_no_pulse", 32'(n_pulse - base), 32'd0);
        key_on = 1'b0;
        tick(4);

        // Release chatter at row 2, column 0
        base    = n_pulse;
        key_row = 3'd2;
        key_pat = 4'b1110;
        key_on  = 1'b1;
        wait_held(1'b1, "chatter_held");
        tick(2);
        held_ok = 1'b1;
        key_on  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            held_ok &= (key_held === 1'b1);
        end
        key_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            held_ok &= (key_held === 1'b1);
        end
        chk("chatter_held_stays", 32'(held_ok), 32'd1);
        chk("chatter_colOut",     32'(colOut), 32'he);
        key_on = 1'b0;
        wait_held(1'b0, "chatter_release");
        chk("chatter_one_pulse", 32'(n_pulse - base), 32'd1);

        // Reset asserted mid-debounce at row 1, column 2
        base    = n_pulse;
        key_row = 3'd1;
        key_pat = 4'b1011;
        key_on  = 1'b1;
        n = 0;
        while (row_drv === 5'b11101 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (row_drv !== 5'b11101 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_row1", 32'(row_drv), 32'h1d);
        tick(6);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid",   32'(key_valid), 32'd0);
        chk("mid_rst_row_drv", 32'(row_drv),   32'h1e);
        chk("mid_rst_colOut",  32'(colOut),    32'hf);
        chk("mid_rst_held",    32'(key_held),  32'd0);
        rst    = 1'b0;
        key_on = 1'b0;
        tick(30);
        chk("mid_no_pulse", 32'(n_pulse - base), 32'd0);

        // Hold a key 100 cycles after acceptance (row 4, column 3)
        base    = n_pulse;
        key_row = 3'd4;
        key_pat = 4'b0111;
        key_on  = 1'b1;
        wait_valid("hold_valid");
        chk("hold_rowOut", 32'(rowOut), 32'h10);
        chk("hold_colOut", 32'(colOut), 32'h7);
        tick(100);
`ifdef KEY_REPEAT_EN
        chk("hold_pulses", 32'(n_pulse - base), 32'd4);
`else
        chk("hold_pulses", 32'(n_pulse - base), 32'd1);
`endif
        key_on = 1'b0;
        wait_held(1'b0, "hold_release");
        chk("hold_rowOut_clr", 32'(rowOut), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
